// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the dmem_responder slice.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

    localparam int unsigned WAIT_CNT_W = 4;

    // Word address of the optional cycle counter for the default 12-bit address map.
    localparam int unsigned DEF_ADDR_W = 12;
    localparam logic [DEF_ADDR_W-1:0] COUNTER_ADDR = '1;

endpackage

// File: rtl/dmem_wait_counter.sv
// Loadable wait-state counter with clear, enable and terminal-count output.
module dmem_wait_counter
    import dmem_responder_pkg::*;
(
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  clear_i,
    input  logic                  load_i,
    input  logic [WAIT_CNT_W-1:0] load_value_i,
    input  logic                  enable_i,
    input  logic [WAIT_CNT_W-1:0] limit_i,
    output logic                  terminal_o
);

    logic [WAIT_CNT_W-1:0] count_q;

    always_ff @(posedge clock_i) begin
        if (reset_i || clear_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_value_i;
        end else if (enable_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign terminal_o = (count_q == limit_i);

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states, one-cycle response.
// Optional macro DMEM_RESPONDER_CYCLE_COUNTER_EN maps a free-running cycle counter at the top address.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              req_wren,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT =
        (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              wren_q;
    logic              accept;
    logic              wait_done;
    logic              enter_resp;

    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              acc_wren;
    logic              acc_in_range;
    logic              acc_ctr;
    logic [DATA_W-1:0] ctr_value;
    logic [DATA_W-1:0] load_data;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (req_valid) state_d = (WAIT_CYCLES > 0) ? StWait : StResp;
            StWait:  if (wait_done) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == StIdle);
        resp_valid = (state_q == StResp);
        resp_err   = resp_valid && err_q;
    end

    assign resp_rdata = rdata_q;
    assign accept     = req_valid && req_ready;
    assign enter_resp = (state_d == StResp) && (state_q != StResp);

    dmem_wait_counter u_wait_counter (
        .clock_i      (clock),
        .reset_i      (reset),
        .clear_i      (state_q == StResp),
        .load_i       (accept),
        .load_value_i ('0),
        .enable_i     (state_q == StWait),
        .limit_i      (WAIT_LIMIT),
        .terminal_o   (wait_done)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wren_q  <= 1'b0;
        end else if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wren_q  <= req_wren;
        end
    end

    // With zero wait states the access happens on the acceptance edge, before the latch updates.
    assign acc_addr     = (state_q == StIdle) ? req_addr  : addr_q;
    assign acc_wdata    = (state_q == StIdle) ? req_wdata : wdata_q;
    assign acc_wren     = (state_q == StIdle) ? req_wren  : wren_q;
    assign acc_in_range = (32'(acc_addr) < DEPTH);

`ifdef DMEM_RESPONDER_CYCLE_COUNTER_EN
    logic [31:0] cycle_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
        end
    end

    assign acc_ctr   = (acc_addr == {ADDR_W{1'b1}});
    assign ctr_value = DATA_W'(cycle_q);
`else
    assign acc_ctr   = 1'b0;
    assign ctr_value = '0;
`endif

    always_comb begin
        load_data = '0;
        if (acc_ctr) begin
            load_data = ctr_value;
        end else if (acc_in_range) begin
            load_data = mem[acc_addr[IDX_W-1:0]];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && enter_resp && acc_wren && acc_in_range && !acc_ctr) begin
            mem[acc_addr[IDX_W-1:0]] <= acc_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (enter_resp) begin
            rdata_q <= acc_wren ? '0 : load_data;
            err_q   <= !acc_in_range && !acc_ctr;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder with a WAIT_CYCLES=2 and a WAIT_CYCLES=0 instance.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int unsigned DEPTH = 1024;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  req_valid, req_wren, req_ready, resp_valid, resp_err;
    logic [11:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic [31:0] resp_rdata [2];

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_mem [2][DEPTH];
    logic [31:0] cyc_model;
    logic [31:0] rd, rd_a, rd_b;

    always #5 clock = ~clock;

    // Reference free-running cycle count: cleared by reset, +1 per clock otherwise.
    always @(posedge clock) begin
        if (reset) cyc_model <= '0;
        else       cyc_model <= cyc_model + 32'd1;
    end

    dmem_responder #(
        .ADDR_W      (12),
        .DATA_W      (32),
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (2)
    ) u_dut_w2 (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid[0]),
        .req_ready  (req_ready[0]),
        .req_addr   (req_addr[0]),
        .req_wdata  (req_wdata[0]),
        .req_wren   (req_wren[0]),
        .resp_valid (resp_valid[0]),
        .resp_rdata (resp_rdata[0]),
        .resp_err   (resp_err[0])
    );

    dmem_responder #(
        .ADDR_W      (12),
        .DATA_W      (32),
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (0)
    ) u_dut_w0 (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid[1]),
        .req_ready  (req_ready[1]),
        .req_addr   (req_addr[1]),
        .req_wdata  (req_wdata[1]),
        .req_wren   (req_wren[1]),
        .resp_valid (resp_valid[1]),
        .resp_rdata (resp_rdata[1]),
        .resp_err   (resp_err[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int unsigned wait_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    // One complete transaction; expectations come from the memory model and the latency rule.
    task automatic txn(input int d, input logic wr, input logic [11:0] a, input logic [31:0] wd,
                       output logic [31:0] rdata);
        int unsigned w;
        logic [31:0] prev_cyc, exp_rd;
        logic        exp_err, ctr_hit;
        w = wait_of(d);
        rdata = '0;
        @(negedge clock);
        req_valid[d] = 1'b1;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        req_wren[d]  = wr;
        prev_cyc     = cyc_model;
        check($sformatf("ready_idle d%0d", d), 32'(req_ready[d]), 32'd1);
        @(posedge clock);
        for (int k = 1; k <= int'(w) + 1; k++) begin
            @(negedge clock);
            // Garbage on the request lines while busy must be ignored.
            req_valid[d] = (k < int'(w) + 1) ? 1'($urandom) : 1'b0;
            req_addr[d]  = 12'($urandom);
            req_wdata[d] = $urandom;
            req_wren[d]  = 1'($urandom);
            check($sformatf("ready_busy d%0d k%0d", d, k), 32'(req_ready[d]), 32'd0);
            check($sformatf("resp_valid d%0d k%0d", d, k), 32'(resp_valid[d]),
                  32'(k == int'(w) + 1));
            if (k == int'(w) + 1) begin
                ctr_hit = 1'b0;
`ifdef DMEM_RESPONDER_CYCLE_COUNTER_EN
                ctr_hit = (a == COUNTER_ADDR);
`endif
                if (ctr_hit) begin
                    exp_err = 1'b0;
                    exp_rd  = wr ? 32'd0 : prev_cyc;
                end else if (int'(a) < int'(DEPTH)) begin
                    exp_err = 1'b0;
                    if (wr) begin
                        model_mem[d][a[9:0]] = wd;
                        exp_rd = 32'd0;
                    end else begin
                        exp_rd = model_mem[d][a[9:0]];
                    end
                end else begin
                    exp_err = 1'b1;
                    exp_rd  = 32'd0;
                end
                check($sformatf("rdata d%0d a%03h wr%0d", d, a, wr), resp_rdata[d], exp_rd);
                check($sformatf("err d%0d a%03h wr%0d", d, a, wr), 32'(resp_err[d]),
                      32'(exp_err));
                rdata = resp_rdata[d];
            end else begin
                prev_cyc = cyc_model;
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_wren  = '0;
        for (int d = 0; d < 2; d++) begin
            req_addr[d]  = '0;
            req_wdata[d] = '0;
        end

        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst ready d%0d", d), 32'(req_ready[d]), 32'd1);
            check($sformatf("rst valid d%0d", d), 32'(resp_valid[d]), 32'd0);
            check($sformatf("rst rdata d%0d", d), resp_rdata[d], 32'd0);
            check($sformatf("rst err d%0d", d), 32'(resp_err[d]), 32'd0);
        end

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) txn(d, 1'b1, 12'(i), $urandom, rd);
        end

        // Store then load, read-after-write.
        txn(0, 1'b1, 12'h005, 32'hDEADBEEF, rd);
        txn(0, 1'b0, 12'h005, 32'h0, rd);
        check("raw 0x005", rd, 32'hDEADBEEF);

        // Out of range: store dropped, load returns 0, low word untouched.
        txn(0, 1'b1, 12'h400, 32'h12345678, rd);
        txn(0, 1'b0, 12'h400, 32'h0, rd);
        txn(0, 1'b0, 12'h000, 32'h0, rd);

        // Zero-wait back-to-back loads with req_valid held high.
        @(negedge clock);
        req_valid[1] = 1'b1;
        req_wren[1]  = 1'b0;
        req_addr[1]  = 12'h000;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            @(negedge clock);
            check($sformatf("b2b valid %0d", i), 32'(resp_valid[1]), 32'd1);
            check($sformatf("b2b rdata %0d", i), resp_rdata[1], model_mem[1][i]);
            check($sformatf("b2b err %0d", i), 32'(resp_err[1]), 32'd0);
            req_addr[1] = 12'(i + 1);
            @(negedge clock);
            check($sformatf("b2b idle valid %0d", i), 32'(resp_valid[1]), 32'd0);
            check($sformatf("b2b idle ready %0d", i), 32'(req_ready[1]), 32'd1);
            if (i == 3) req_valid[1] = 1'b0;
        end

        // Reset during WAIT abandons the store.
        txn(0, 1'b1, 12'h010, 32'hA5A5_0010, rd);
        @(negedge clock);
        req_valid[0] = 1'b1;
        req_wren[0]  = 1'b1;
        req_addr[0]  = 12'h010;
        req_wdata[0] = 32'hCAFE_0010;
        @(posedge clock);
        @(negedge clock);
        req_valid[0] = 1'b0;
        reset        = 1'b1;
        @(negedge clock);
        check("midrst valid a", 32'(resp_valid[0]), 32'd0);
        @(negedge clock);
        check("midrst valid b", 32'(resp_valid[0]), 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check($sformatf("midrst quiet %0d", k), 32'(resp_valid[0]), 32'd0);
        end
        txn(0, 1'b0, 12'h010, 32'h0, rd);

        // Two loads of the top address accepted 10 cycles apart.
        txn(0, 1'b0, 12'hFFF, 32'h0, rd_a);
        repeat (6) @(negedge clock);
        txn(0, 1'b0, 12'hFFF, 32'h0, rd_b);
`ifdef DMEM_RESPONDER_CYCLE_COUNTER_EN
        check("ctr delta", rd_b - rd_a, 32'd10);
`endif
        txn(0, 1'b1, 12'hFFF, 32'h1234, rd);

        for (int n = 0; n < 80; n++) begin
            int          d;
            int unsigned r;
            d = int'($urandom_range(0, 1));
            r = $urandom_range(0, 7);
            if (r < 3)       txn(d, 1'b1, 12'($urandom_range(0, 15)), $urandom, rd);
            else if (r < 6)  txn(d, 1'b0, 12'($urandom_range(0, 15)), 32'h0, rd);
            else if (r == 6) txn(d, 1'b1, 12'($urandom_range(16, 1023)), $urandom, rd);
            else             txn(d, 1'($urandom), 12'($urandom_range(1024, 4094)), $urandom, rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
